// File: rtl/two_req_rr_arbiter.sv
// Round-robin arbiter sharing one 4-bit channel between requesters A and B,
// with a per-grant burst limit and a single registered output stage (1-cycle latency).
module two_req_rr_arbiter #(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CW        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic [3:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [3:0] b_data,
  output logic       b_ready,
  output logic       out_valid,
  output logic [3:0] out_data,
  input  logic       out_ready,
  output logic       sel,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_e;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_inc;
  logic            last_b_q;
  logic            sel_q;
  logic            out_valid_q, out_valid_d;
  logic [3:0]      out_data_q, out_data_d;
  logic            stage_free;
  logic            a_acc, b_acc;
  logic            burst_done;

  assign stage_free = !out_valid_q || out_ready;
  assign a_ready    = !rst && (state_q == GNT_A) && stage_free;
  assign b_ready    = !rst && (state_q == GNT_B) && stage_free;
  assign a_acc      = a_valid && a_ready;
  assign b_acc      = b_valid && b_ready;
  assign cnt_inc    = cnt_q + 1'b1;
  assign burst_done = (cnt_inc == MAX_CNT);

  // Grant FSM; a grant is only released early when the holder drops valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_b_q <= 1'b1;
      sel_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (a_valid && (!b_valid || last_b_q)) begin
            state_q <= GNT_A;
            sel_q   <= 1'b0;
          end else if (b_valid) begin
            state_q <= GNT_B;
            sel_q   <= 1'b1;
          end
        end
        GNT_A: begin
          if (!a_valid) begin
            cnt_q    <= '0;
            last_b_q <= 1'b0;
            if (b_valid) begin
              state_q <= GNT_B;
              sel_q   <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else if (a_acc) begin
            if (burst_done) begin
              cnt_q <= '0;
              if (b_valid) begin
                state_q  <= GNT_B;
                sel_q    <= 1'b1;
                last_b_q <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        GNT_B: begin
          if (!b_valid) begin
            cnt_q    <= '0;
            last_b_q <= 1'b1;
            if (a_valid) begin
              state_q <= GNT_A;
              sel_q   <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end else if (b_acc) begin
            if (burst_done) begin
              cnt_q <= '0;
              if (a_valid) begin
                state_q  <= GNT_A;
                sel_q    <= 1'b0;
                last_b_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (a_acc) begin
      out_valid_d = 1'b1;
      out_data_d  = a_data;
    end else if (b_acc) begin
      out_valid_d = 1'b1;
      out_data_d  = b_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sel       = sel_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_two_req_rr_arbiter.sv
// Randomized bench: a transaction-level arbitration model plus an accept-order
// scoreboard predict every ready, output and grant signal each cycle.
module tb_two_req_rr_arbiter;

  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid, b_valid, out_ready;
  logic [3:0] a_data, b_data;
  logic       a_ready, b_ready, out_valid, sel, busy;
  logic [3:0] out_data;

  two_req_rr_arbiter #(.MAX_BURST(MAXB), .CW(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: owner 0 = nobody, 1 = A, 2 = B; used = beats taken in this burst.
  int         m_own  = 0;
  int         m_used = 0;
  int         m_last = 2;
  bit         m_sel  = 1'b0;
  bit         m_ov   = 1'b0;
  logic [3:0] m_od   = 4'h0;
  logic [3:0] sb[$];
  logic [3:0] a_seq  = 4'h1;
  logic [3:0] b_seq  = 4'h8;

  task automatic cycle(input int pa, input int pb, input int pr, input int prst, input bit chk);
    bit free, ea, eb, acc_a, acc_b, xv, yv, xacc;
    int other;
    rst       = ($urandom_range(0, 99) < prst);
    a_valid   = ($urandom_range(0, 99) < pa);
    b_valid   = ($urandom_range(0, 99) < pb);
    out_ready = ($urandom_range(0, 99) < pr);
    a_data    = a_seq;
    b_data    = b_seq;
    #1;
    free = !m_ov || out_ready;
    ea   = !rst && (m_own == 1) && free;
    eb   = !rst && (m_own == 2) && free;
    if (chk) begin
      check("a_ready", 8'(a_ready), 8'(ea));
      check("b_ready", 8'(b_ready), 8'(eb));
      check("out_valid", 8'(out_valid), 8'(m_ov));
      check("out_data", 8'(out_data), 8'(m_od));
      check("sel", 8'(sel), 8'(m_sel));
      check("busy", 8'(busy), 8'(m_own != 0));
    end
    if (rst) begin
      m_own = 0; m_used = 0; m_last = 2; m_sel = 1'b0;
      m_ov = 1'b0; m_od = 4'h0;
      sb.delete();
    end else begin
      acc_a = a_valid && ea;
      acc_b = b_valid && eb;
      if (m_ov && out_ready) begin
        if (sb.size() == 0) check("sb_underflow", 8'd1, 8'd0);
        else if (chk) check("deliver_order", 8'(out_data), 8'(sb.pop_front()));
        else void'(sb.pop_front());
      end
      if (acc_a) begin
        sb.push_back(a_data); m_ov = 1'b1; m_od = a_data; a_seq = a_seq + 4'h1;
      end else if (acc_b) begin
        sb.push_back(b_data); m_ov = 1'b1; m_od = b_data; b_seq = b_seq + 4'h1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (m_own == 0) begin
        if (a_valid && b_valid) m_own = (m_last == 1) ? 2 : 1;
        else if (a_valid)       m_own = 1;
        else if (b_valid)       m_own = 2;
      end else begin
        other = 3 - m_own;
        xv    = (m_own == 1) ? a_valid : b_valid;
        yv    = (m_own == 1) ? b_valid : a_valid;
        xacc  = (m_own == 1) ? acc_a : acc_b;
        if (!xv) begin
          m_used = 0; m_last = m_own;
          m_own  = yv ? other : 0;
        end else if (xacc) begin
          m_used++;
          if (m_used == MAXB) begin
            m_used = 0;
            if (yv) begin
              m_last = m_own; m_own = other;
            end
          end
        end
      end
      if (m_own != 0) m_sel = (m_own == 2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input int pa, input int pb, input int pr, input int prst);
    for (int i = 0; i < n; i++) cycle(pa, pb, pr, prst, 1'b1);
  endtask

  initial begin
    cycle(0, 0, 100, 100, 1'b0);     // establish known state
    run(2, 100, 100, 100, 100);      // readies must stay low while in reset
    run(8, 100, 0, 100, 0);          // A streams alone, burst wraps
    run(1, 0, 0, 100, 100);
    run(14, 100, 100, 100, 0);       // both valid from IDLE: A first, alternating bursts
    run(3, 0, 100, 100, 0);          // A drops, B takes over
    run(2, 100, 0, 100, 0);
    run(5, 100, 100, 0, 0);          // stalled consumer
    run(4, 100, 100, 100, 0);
    run(300, 70, 70, 70, 2);         // random traffic with occasional reset
    run(300, 30, 85, 50, 2);
    run(300, 95, 95, 90, 1);
    run(10, 0, 0, 100, 0);           // idle drain
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
